serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 161 ++++++++++++++++
 tb/tb_serial_adder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial adder/subtractor. A single full-adder cell and a
//             carry flip-flop are reused over WIDTH clock cycles to produce a
//             WIDTH-bit sum (a+b+cin) or difference (a-b-cin), together with
//             carry-out and signed overflow. A start/busy/done handshake lets
//             a controller issue back-to-back operations.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH    operand/result width in bits (2..32)
//  Ports
//    clk      rising-edge clock
//    rst      synchronous, active-high reset
//    start_i  request a new operation (ignored while busy_o=1)
//    sub_i    0: a+b+cin, 1: a-b-cin (sampled with start_i)
//    a_i      operand A (sampled with start_i)
//    b_i      operand B (sampled with start_i)
//    cin_i    carry-in / borrow-in (sampled with start_i)
//    busy_o   high while bits are being processed
//    done_o   one-cycle pulse in the cycle results are updated
//    sum_o    registered result, held until the next completion
//    cout_o   carry-out; in subtract mode 1 means no borrow
//    ovf_o    signed overflow (carry into MSB XOR carry out of MSB)
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;      // operand A shift register
  logic [WIDTH-1:0]   sb_q, sb_d;      // operand B (or ~B) shift register
  // Partial-result register only needs WIDTH-1 bits: the last sum bit goes
  // straight from the adder into sum_q on the completion edge.
  logic [WIDTH-2:0]   sr_q, sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  // Shared full-adder cell
  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   sr_shifted;      // new sum bit entering from the MSB side

  assign fa_sum     = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign fa_carry   = (sa_q[0] & sb_q[0]) | (carry_q & (sa_q[0] ^ sb_q[0]));
  assign sr_shifted = {fa_sum, sr_q};

  // --------------------------------------------------------------------------
  // Next-state, datapath and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          // Subtraction is a + ~b + ~cin, so invert B and the borrow-in once
          // here and run the same adder afterwards.
          sa_d    = a_i;
          sb_d    = sub_i ? ~b_i : b_i;
          carry_d = cin_i ^ sub_i;
          sr_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        sr_d    = sr_shifted[WIDTH-1:1];
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB at this point.
          sum_d   = sr_shifted;
          cout_d  = fa_carry;
          ovf_d   = carry_q ^ fa_carry;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder at WIDTH = 8, 16 and 2.
//             Expected results come from an arithmetic reference model and
//             are queued when an operation is issued, then popped when the
//             DUT pulses done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  // Index 0: WIDTH=8, 1: WIDTH=16, 2: WIDTH=2
  logic        st [3];
  logic        sb [3];
  logic        ci [3];
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic        bz [3];
  logic        dn [3];
  logic        co [3];
  logic        ov [3];
  logic [31:0] sm [3];
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic [1:0]  sum2;

  assign sm[0] = {24'd0, sum8};
  assign sm[1] = {16'd0, sum16};
  assign sm[2] = {30'd0, sum2};

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(st[0]), .sub_i(sb[0]),
    .a_i(av[0][7:0]), .b_i(bv[0][7:0]), .cin_i(ci[0]),
    .busy_o(bz[0]), .done_o(dn[0]), .sum_o(sum8), .cout_o(co[0]), .ovf_o(ov[0])
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start_i(st[1]), .sub_i(sb[1]),
    .a_i(av[1][15:0]), .b_i(bv[1][15:0]), .cin_i(ci[1]),
    .busy_o(bz[1]), .done_o(dn[1]), .sum_o(sum16), .cout_o(co[1]), .ovf_o(ov[1])
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(st[2]), .sub_i(sb[2]),
    .a_i(av[2][1:0]), .b_i(bv[2][1:0]), .cin_i(ci[2]),
    .busy_o(bz[2]), .done_o(dn[2]), .sum_o(sum2), .cout_o(co[2]), .ovf_o(ov[2])
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sbq [$];

  logic [31:0] b2b_a [3] = '{32'h01, 32'h02, 32'h7F};
  logic [31:0] b2b_b [3] = '{32'h01, 32'h02, 32'h01};

  function automatic int wid(input int d);
    case (d)
      0:       return 8;
      1:       return 16;
      default: return 2;
    endcase
  endfunction

  // Reference: plain integer addition for sum/cout, and a separate sum of the
  // low WIDTH-1 bits for the carry into the MSB.
  function automatic exp_t model(input int w, input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input logic c);
    logic [33:0] mask, m1, aa, bb, full, low;
    logic        cc;
    exp_t        r;
    mask  = (34'd1 << w) - 34'd1;
    m1    = (34'd1 << (w - 1)) - 34'd1;
    aa    = {2'b00, a} & mask;
    bb    = {2'b00, (s ? ~b : b)} & mask;
    cc    = s ? ~c : c;
    full  = aa + bb + {33'd0, cc};
    low   = (aa & m1) + (bb & m1) + {33'd0, cc};
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = low[w-1] ^ full[w];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one operation on DUT d and check its completion. With noise set,
  // start is held high with random operands while busy; those must be ignored.
  task automatic run_op(input int d, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic c, input bit noise);
    exp_t e;
    int   w;
    int   lat;
    int   busyc;
    bit   got;
    w = wid(d); lat = 0; busyc = 0; got = 1'b0;
    @(negedge clk);
    st[d] = 1'b1; sb[d] = s; av[d] = a; bv[d] = b; ci[d] = c;
    sbq.push_back(model(w, s, a, b, c));
    @(posedge clk);
    for (int i = 0; i < w + 4; i++) begin
      @(negedge clk);
      if (dn[d]) begin
        got = 1'b1;
        st[d] = 1'b0;
        break;
      end
      st[d] = noise;
      if (noise) begin
        sb[d] = 1'($urandom_range(0, 1));
        av[d] = $urandom;
        bv[d] = $urandom;
        ci[d] = 1'($urandom_range(0, 1));
      end
      if (bz[d]) busyc++;
      @(posedge clk);
      lat++;
    end
    st[d] = 1'b0;
    e = sbq.pop_front();
    chk($sformatf("w%0d_done_seen", w), 32'(got), 32'd1);
    if (got) begin
      chk($sformatf("w%0d_sum", w),          sm[d],        e.sum);
      chk($sformatf("w%0d_cout", w),         32'(co[d]),   32'(e.cout));
      chk($sformatf("w%0d_ovf", w),          32'(ov[d]),   32'(e.ovf));
      chk($sformatf("w%0d_latency", w),      32'(lat),     32'(w));
      chk($sformatf("w%0d_busy_cycles", w),  32'(busyc),   32'(w));
      chk($sformatf("w%0d_busy_in_done", w), 32'(bz[d]),   32'd0);
      @(negedge clk);
      chk($sformatf("w%0d_done_one_cycle", w), 32'(dn[d]), 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    int   k;
    int   last;
    int   pulses;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; sb[d] = 1'b0; ci[d] = 1'b0; av[d] = '0; bv[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    chk("rst_done", 32'(dn[0]), 32'd0);
    chk("rst_sum",  sm[0],      32'd0);
    chk("rst_cout", 32'(co[0]), 32'd0);
    chk("rst_ovf",  32'(ov[0]), 32'd0);
    rst = 1'b0;

    // Directed WIDTH=8 cases
    run_op(0, 1'b0, 32'h5A, 32'h33, 1'b0, 1'b0);
    run_op(0, 1'b0, 32'hFF, 32'h00, 1'b1, 1'b0);
    run_op(0, 1'b1, 32'h10, 32'h20, 1'b0, 1'b0);
    run_op(0, 1'b1, 32'h80, 32'h01, 1'b0, 1'b1);

    // Back-to-back with start held high
    @(negedge clk);
    st[0] = 1'b1; sb[0] = 1'b0; ci[0] = 1'b0; av[0] = b2b_a[0]; bv[0] = b2b_b[0];
    for (int j = 0; j < 3; j++) sbq.push_back(model(8, 1'b0, b2b_a[j], b2b_b[j], 1'b0));
    k = 0; last = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge clk);
      if (dn[0]) begin
        e = sbq.pop_front();
        chk("b2b_sum",  sm[0],      e.sum);
        chk("b2b_cout", 32'(co[0]), 32'(e.cout));
        chk("b2b_ovf",  32'(ov[0]), 32'(e.ovf));
        if (k > 0) chk("b2b_spacing", 32'(cyc - last), 32'd9);
        last = cyc;
        k++;
        if (k < 3) begin
          av[0] = b2b_a[k];
          bv[0] = b2b_b[k];
        end else begin
          st[0] = 1'b0;
        end
      end
    end
    st[0] = 1'b0;
    chk("b2b_count", 32'(k), 32'd3);
    sbq.delete();

    // Reset while processing bit 4 of 0xAA + 0x55
    @(negedge clk);
    st[0] = 1'b1; sb[0] = 1'b0; ci[0] = 1'b0; av[0] = 32'hAA; bv[0] = 32'h55;
    @(posedge clk);
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bz[0]), 32'd0);
    chk("abort_done", 32'(dn[0]), 32'd0);
    chk("abort_sum",  sm[0],      32'd0);
    chk("abort_cout", 32'(co[0]), 32'd0);
    chk("abort_ovf",  32'(ov[0]), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dn[0]) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op(0, 1'b0, 32'h01, 32'h01, 1'b0, 1'b0);

    // Reset wins over start in the same cycle
    @(negedge clk);
    rst = 1'b1; st[0] = 1'b1; av[0] = 32'h03; bv[0] = 32'h03;
    @(negedge clk);
    chk("prio_busy", 32'(bz[0]), 32'd0);
    rst = 1'b0; st[0] = 1'b0;

    // WIDTH=2 exhaustive, both modes
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          for (int c = 0; c < 2; c++)
            run_op(2, 1'(s), 32'(a), 32'(b), 1'(c), 1'b0);

    // WIDTH=16 random
    for (int i = 0; i < 1000; i++)
      run_op(1, 1'($urandom_range(0, 1)), $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
